// File: rtl/dmem_access_ctrl_if.sv
// Execute-stage request/response handshake plus the word-wide data memory port.
interface dmem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemWrite;
  logic        Memread;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;

  // slave: the access controller; master: the execute stage plus the memory model
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready, readData,
    output req_ready, resp_valid, resp_rdata, resp_err, MemWrite, Memread, address, writeData
  );
  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready, readData,
    input  req_ready, resp_valid, resp_rdata, resp_err, MemWrite, Memread, address, writeData
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store access controller driving a word-addressed data memory.
// Sub-word stores are read-modify-write; bad accesses are answered without touching memory.
//
// state | meaning
// IDLE  | req_ready=1, memory outputs 0
// ACC   | first memory cycle (read, or write for SW)
// WR    | write half of a SH/SB read-modify-write
// RESP  | resp_valid=1 until resp_ready
module dmem_access_ctrl #(
  parameter int unsigned DEPTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  dmem_access_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, WR, RESP} state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_op;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic        r_mem_read, r_mem_write, r_resp_err;
  logic [31:0] r_address, r_write_data, r_resp_rdata;

  logic        w_mem_read, w_mem_write, w_resp_err, w_accept;
  logic [31:0] w_address, w_write_data, w_resp_rdata;
  logic        w_misaligned, w_out_of_range;
  logic [4:0]  w_shamt;
  logic [31:0] w_rd_shifted, w_load_data, w_lane_mask, w_lane_data, w_merged;
  logic [15:0] w_rd_half;
  logic [7:0]  w_rd_byte;

  always_comb begin
    w_misaligned = 1'b0;
    case (bus.req_op)
      OP_LW, OP_SW:         w_misaligned = |bus.req_addr[1:0];
      OP_LH, OP_LHU, OP_SH: w_misaligned = bus.req_addr[0];
      default:              w_misaligned = 1'b0;
    endcase
  end

  assign w_out_of_range = {2'b00, bus.req_addr[31:2]} >= DEPTH_W;

  // little-endian lane extraction from the word returned in ACC
  assign w_shamt      = {r_lane, 3'b000};
  assign w_rd_shifted = bus.readData >> w_shamt;
  assign w_rd_byte    = w_rd_shifted[7:0];
  assign w_rd_half    = r_lane[1] ? bus.readData[31:16] : bus.readData[15:0];

  always_comb begin
    w_load_data = 32'h0;
    case (r_op)
      OP_LW:   w_load_data = bus.readData;
      OP_LH:   w_load_data = {{16{w_rd_half[15]}}, w_rd_half};
      OP_LHU:  w_load_data = {16'h0, w_rd_half};
      OP_LB:   w_load_data = {{24{w_rd_byte[7]}}, w_rd_byte};
      OP_LBU:  w_load_data = {24'h0, w_rd_byte};
      default: w_load_data = 32'h0;
    endcase
  end

  assign w_lane_mask = (r_op == OP_SB) ? (32'h0000_00FF << w_shamt)
                     : (r_lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF);
  assign w_lane_data = (r_op == OP_SB) ? ({24'h0, r_wdata[7:0]} << w_shamt)
                     : (r_lane[1] ? {r_wdata[15:0], 16'h0} : {16'h0, r_wdata[15:0]});
  assign w_merged    = (bus.readData & ~w_lane_mask) | (w_lane_data & w_lane_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_address    <= 32'h0;
      r_write_data <= 32'h0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_address    <= w_address;
      r_write_data <= w_write_data;
      r_resp_rdata <= w_resp_rdata;
      r_resp_err   <= w_resp_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= OP_LW;
      r_lane  <= 2'b00;
      r_wdata <= 32'h0;
    end else if (w_accept) begin
      r_op    <= bus.req_op;
      r_lane  <= bus.req_addr[1:0];
      r_wdata <= bus.req_wdata;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_address    = 32'h0;
    w_write_data = 32'h0;
    w_resp_rdata = r_resp_rdata;
    w_resp_err   = r_resp_err;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        w_resp_rdata = 32'h0;
        w_resp_err   = 1'b0;
        if (bus.req_valid) begin
          w_accept = 1'b1;
          if (w_misaligned || w_out_of_range) begin
            w_state_nxt = RESP;
            w_resp_err  = 1'b1;
          end else begin
            w_state_nxt = ACC;
            w_address   = {2'b00, bus.req_addr[31:2]};
            if (bus.req_op == OP_SW) begin
              w_mem_write  = 1'b1;
              w_write_data = bus.req_wdata;
            end else begin
              w_mem_read = 1'b1;
            end
          end
        end
      end
      ACC: begin
        if (r_op == OP_SH || r_op == OP_SB) begin
          w_state_nxt  = WR;
          w_mem_write  = 1'b1;
          w_address    = r_address;
          w_write_data = w_merged;
        end else begin
          w_state_nxt  = RESP;
          w_resp_rdata = w_load_data;
        end
      end
      WR:   w_state_nxt = RESP;
      RESP: begin
        if (bus.resp_ready) begin
          w_state_nxt  = IDLE;
          w_resp_rdata = 32'h0;
          w_resp_err   = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.Memread    = r_mem_read;
  assign bus.MemWrite   = r_mem_write;
  assign bus.address    = r_address;
  assign bus.writeData  = r_write_data;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a 32-word memory model on the data port.
module tb_dmem_access_ctrl;
  localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011;
  localparam logic [2:0] LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_access_ctrl_if bus();
  dmem_access_ctrl #(.DEPTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem [0:31];
  assign bus.readData = bus.Memread ? mem[bus.address[4:0]] : 32'h0;
  always @(negedge clk) if (bus.MemWrite) mem[bus.address[4:0]] <= bus.writeData;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] o_rdata, o_rd_addr, o_wr_addr, o_wr_data;
  logic        o_err, o_both;
  int          o_lat, o_nrd, o_nwr, o_rd_k, o_wr_k;

  // issue one request, record strobes per cycle after acceptance and the response
  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit hold);
    o_lat = 99; o_nrd = 0; o_nwr = 0; o_rd_k = 0; o_wr_k = 0; o_both = 1'b0;
    o_rdata = 32'hx; o_err = 1'bx; o_rd_addr = 32'h0; o_wr_addr = 32'h0; o_wr_data = 32'h0;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_op = SB; bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = 32'h0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.Memread)  begin o_nrd++; o_rd_k = k; o_rd_addr = bus.address; end
      if (bus.MemWrite) begin o_nwr++; o_wr_k = k; o_wr_addr = bus.address; o_wr_data = bus.writeData; end
      if (bus.Memread && bus.MemWrite) o_both = 1'b1;
      if (bus.resp_valid) begin o_lat = k; o_rdata = bus.resp_rdata; o_err = bus.resp_err; break; end
    end
    if (!hold) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    n_tests++; if ({bus.resp_err, bus.resp_rdata} !== 33'h0) begin n_fail++; $display("FAIL reset_resp: got err=%b rdata=%h want 0", bus.resp_err, bus.resp_rdata); end
    n_tests++; if ({bus.MemWrite, bus.Memread} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got wr=%b rd=%b want 0", bus.MemWrite, bus.Memread); end
    n_tests++; if ({bus.address, bus.writeData} !== 64'h0) begin n_fail++; $display("FAIL reset_addr_data: got %h/%h want 0", bus.address, bus.writeData); end
  endtask

  task automatic test_sw_lw;
    run_req(SW, 32'h08, 32'hDEAD_BEEF, 1'b0);
    n_tests++; if (o_nwr !== 1 || o_wr_k !== 1) begin n_fail++; $display("FAIL sw_wr_strobe: got n=%0d cyc=%0d want 1/1", o_nwr, o_wr_k); end
    n_tests++; if (o_wr_addr !== 32'd2 || o_wr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wr_word: got %h/%h want 2/deadbeef", o_wr_addr, o_wr_data); end
    n_tests++; if (o_nrd !== 0) begin n_fail++; $display("FAIL sw_no_read: got %0d want 0", o_nrd); end
    n_tests++; if (o_lat !== 2 || o_err !== 1'b0 || o_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_resp: got lat=%0d err=%b rdata=%h want 2/0/0", o_lat, o_err, o_rdata); end
    run_req(LW, 32'h08, 32'h0, 1'b0);
    n_tests++; if (o_nrd !== 1 || o_rd_k !== 1 || o_rd_addr !== 32'd2 || o_nwr !== 0) begin n_fail++; $display("FAIL lw_read_strobe: got n=%0d cyc=%0d addr=%h nwr=%0d want 1/1/2/0", o_nrd, o_rd_k, o_rd_addr, o_nwr); end
    n_tests++; if (o_lat !== 2 || o_err !== 1'b0 || o_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_resp: got lat=%0d err=%b rdata=%h want 2/0/deadbeef", o_lat, o_err, o_rdata); end
  endtask

  task automatic test_load_ext;
    logic [2:0]  t_op   [8] = '{LB, LBU, LH, LHU, LB, LBU, LH, LW};
    logic [31:0] t_addr [8] = '{32'h0B, 32'h0B, 32'h0A, 32'h08, 32'h08, 32'h09, 32'h08, 32'h08};
    logic [31:0] t_exp  [8] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8899, 32'h0000_AABB,
                                32'hFFFF_FFBB, 32'h0000_00AA, 32'hFFFF_AABB, 32'h8899_AABB};
    run_req(SW, 32'h08, 32'h8899_AABB, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_req(t_op[i], t_addr[i], 32'h0, 1'b0);
      n_tests++;
      if (o_rdata !== t_exp[i] || o_err !== 1'b0 || o_lat !== 2) begin
        n_fail++; $display("FAIL load_ext[%0d]: got rdata=%h err=%b lat=%0d want %h/0/2", i, o_rdata, o_err, o_lat, t_exp[i]);
      end
    end
  endtask

  task automatic test_rmw;
    logic [2:0]  t_op   [4] = '{SB, SH, SH, SB};
    logic [31:0] t_addr [4] = '{32'h0D, 32'h0E, 32'h0C, 32'h0F};
    logic [31:0] t_wd   [4] = '{32'hFFFF_FF55, 32'h9999_ABCD, 32'h0000_1234, 32'h0000_0077};
    logic [31:0] t_exp  [4] = '{32'h1122_5544, 32'hABCD_5544, 32'hABCD_1234, 32'h77CD_1234};
    run_req(SW, 32'h0C, 32'h1122_3344, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_req(t_op[i], t_addr[i], t_wd[i], 1'b0);
      n_tests++;
      if (o_nrd !== 1 || o_rd_k !== 1 || o_nwr !== 1 || o_wr_k !== 2 || o_both !== 1'b0 || o_wr_addr !== 32'd3) begin
        n_fail++; $display("FAIL rmw_seq[%0d]: got rd=%0d@%0d wr=%0d@%0d addr=%h both=%b want rd 1@1 wr 1@2 addr 3", i, o_nrd, o_rd_k, o_nwr, o_wr_k, o_wr_addr, o_both);
      end
      n_tests++;
      if (o_wr_data !== t_exp[i] || o_lat !== 3 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
        n_fail++; $display("FAIL rmw_word[%0d]: got wdata=%h lat=%0d err=%b rdata=%h want %h/3/0/0", i, o_wr_data, o_lat, o_err, o_rdata, t_exp[i]);
      end
      run_req(LW, 32'h0C, 32'h0, 1'b0);
      n_tests++;
      if (o_rdata !== t_exp[i]) begin n_fail++; $display("FAIL rmw_readback[%0d]: got %h want %h", i, o_rdata, t_exp[i]); end
    end
  endtask

  task automatic test_errors;
    logic [2:0]  t_op   [6] = '{LW, LH, LW, SW, SH, LHU};
    logic [31:0] t_addr [6] = '{32'h06, 32'h03, 32'h80, 32'h80, 32'h0D, 32'hFFFF_FFFC};
    for (int i = 0; i < 6; i++) begin
      run_req(t_op[i], t_addr[i], 32'hFFFF_FFFF, 1'b0);
      n_tests++;
      if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_nrd !== 0 || o_nwr !== 0 || o_lat !== 1) begin
        n_fail++; $display("FAIL err[%0d]: got err=%b rdata=%h rd=%0d wr=%0d lat=%0d want 1/0/0/0/1", i, o_err, o_rdata, o_nrd, o_nwr, o_lat);
      end
    end
    run_req(SW, 32'h7C, 32'h5A5A_0001, 1'b0);
    run_req(LW, 32'h7C, 32'h0, 1'b0);
    n_tests++;
    if (o_err !== 1'b0 || o_rdata !== 32'h5A5A_0001 || o_rd_addr !== 32'd31) begin
      n_fail++; $display("FAIL last_word: got err=%b rdata=%h addr=%h want 0/5a5a0001/1f", o_err, o_rdata, o_rd_addr);
    end
  endtask

  task automatic test_backpressure;
    int bad = 0;
    bus.resp_ready = 1'b0;
    run_req(LW, 32'h08, 32'h0, 1'b1);
    n_tests++; if (o_lat !== 2 || o_rdata !== 32'h8899_AABB) begin n_fail++; $display("FAIL bp_first: got lat=%0d rdata=%h want 2/8899aabb", o_lat, o_rdata); end
    bus.req_valid = 1'b1; bus.req_op = SW; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h8899_AABB || bus.req_ready !== 1'b0 ||
          bus.MemWrite !== 1'b0 || bus.Memread !== 1'b0) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.MemWrite !== 1'b0 || bus.address !== 32'h0) begin
      n_fail++; $display("FAIL bp_release: got rv=%b rr=%b wr=%b addr=%h want 0/1/0/0", bus.resp_valid, bus.req_ready, bus.MemWrite, bus.address);
    end
  endtask

  task automatic test_reset_abort;
    int bad = 0;
    run_req(SW, 32'h04, 32'hCAFE_0001, 1'b0);
    bus.req_valid = 1'b1; bus.req_op = SW; bus.req_addr = 32'h04; bus.req_wdata = 32'h1234_5678;
    @(posedge clk); #2;
    n_tests++; if (bus.MemWrite !== 1'b1) begin n_fail++; $display("FAIL abort_in_acc: got MemWrite=%b want 1", bus.MemWrite); end
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    n_tests++;
    if (bus.MemWrite !== 1'b0 || bus.Memread !== 1'b0 || bus.address !== 32'h0 || bus.writeData !== 32'h0 ||
        bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs: got wr=%b rd=%b addr=%h wd=%h rr=%b rv=%b want 0/0/0/0/1/0", bus.MemWrite, bus.Memread, bus.address, bus.writeData, bus.req_ready, bus.resp_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL abort_no_resp: got %0d cycles with response want 0", bad); end
    run_req(LW, 32'h04, 32'h0, 1'b0);
    n_tests++; if (o_rdata !== 32'hCAFE_0001 || o_err !== 1'b0) begin n_fail++; $display("FAIL abort_word_kept: got %h err=%b want cafe0001/0", o_rdata, o_err); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = LW; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.resp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset;
    test_sw_lw;
    test_load_ext;
    test_rmw;
    test_errors;
    test_backpressure;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Load/store access controller: the initiator side of the word-addressed data memory port. It accepts one load or store request from the execute stage, issues the memory strobes (Memread, MemWrite, address, writeData), and returns the result through a valid/ready response handshake. Byte and halfword stores are done as read-modify-write because the memory port is word-wide. Misaligned and out-of-range accesses are reported and never reach memory.

## Interface
- DEPTH, 32: data memory size in 32-bit words; valid word indices are 0..DEPTH-1.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; sub-word stores use the low bits.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  load result, sign- or zero-extended; 0 for stores and errors.
- resp_err  out  1  misaligned or out-of-range access.
- MemWrite  out  1  memory write strobe.
- Memread  out  1  memory read enable.
- address  out  32  word index, req_addr >> 2.
- writeData  out  32  word written to memory.
- readData  in  32  memory read data; combinational from address when Memread=1.

## Operation
- States:
  - IDLE: req_ready=1, all memory outputs 0.
  - ACC: first memory cycle.
  - WR: write half of a read-modify-write.
  - RESP: resp_valid=1.
- A request is accepted when req_valid=1 and req_ready=1. The op, address and data are registered at that edge.
- Error checks are made on acceptance. An error is raised on either of these conditions:
  - Misalignment: halfword ops with addr[0]=1, or word ops with addr[1:0]!=0.
  - Out of range: req_addr>>2 >= DEPTH.
- On an error the controller goes IDLE→RESP with resp_err=1 and resp_rdata=0. No strobe is asserted.
- Loads: IDLE→ACC→RESP.
  - In ACC, Memread=1 and address=index.
  - readData is captured at the end of ACC.
  - Extraction is little-endian: byte lane addr[1:0], halfword lane addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.
- SW: IDLE→ACC→RESP. In ACC, MemWrite=1 and writeData=req_wdata.
- SH and SB: IDLE→ACC→WR→RESP.
  - In ACC, Memread=1 and the old word is captured.
  - In WR, MemWrite=1, and writeData is the old word with only the addressed lane replaced.
- RESP holds resp_valid, resp_rdata and resp_err stable until resp_ready=1. It then goes to IDLE.
- A new request cannot be accepted in the same cycle as a response handshake.
- Memory outputs are registered and are 0 in every state other than ACC and WR.
- Memread and MemWrite are never asserted together.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, MemWrite=0, Memread=0, address=0, writeData=0.
- Request accepted at edge T:
  - Strobes are asserted during T..T+1.
  - resp_valid=1 from T+1 for loads and SW.
  - resp_valid=1 from T+2 for SH and SB.
  - resp_valid=1 from T+1 for errors.
- Strobes last exactly one cycle. address and writeData are stable for the whole cycle, including the falling edge where memory commits the write.
- The earliest next request is at the edge after the response handshake. Minimum spacing is 3 cycles, or 4 for SH and SB.
- rst_n low mid-operation forces reset values immediately, including MemWrite=0.
  - A store interrupted before its falling edge is not written.
  - No response is issued for the aborted request.
- req_valid=1 while busy is ignored (req_ready=0). Request inputs may change freely while busy.

## Test plan
- SW addr 0x08, data 0xDEADBEEF, then LW 0x08 → MemWrite=1 for one cycle with address=2; resp_rdata=0xDEADBEEF, resp_err=0, response 2 cycles after acceptance.
- With 0x8899AABB at word 2: LB 0x0B → 0xFFFFFF88; LBU 0x0B → 0x00000088; LH 0x0A → 0xFFFF8899; LHU 0x08 → 0x0000AABB.
- With 0x11223344 at word 3: SB 0x0D, data 0x55, then LW 0x0C → 0x11225544. SH 0x0E, data 0xABCD → 0xABCD5544. Each store shows Memread in ACC followed by MemWrite in WR.
- LW 0x06, LH 0x03, and LW 0x80 (index 32) → resp_err=1, resp_rdata=0. Memread and MemWrite stay 0 throughout.
- Hold resp_ready=0 for 5 cycles after a load → resp_valid and resp_rdata are held stable and req_ready=0. Raise resp_ready → IDLE next cycle.
- Drop rst_n during the ACC cycle of SW 0x04, data 0x12345678 → all outputs are reset immediately, word 1 is unchanged (checked by a later LW 0x04), and no response is issued.
